// File: rtl/f1_sweep_checker_pkg.sv
// Shared definitions for the f1 sweep checker.
// Holds the default N_IN and SETTLE values, the FSM state encoding, and a helper
// that sizes the settle counter.
package f1_sweep_checker_pkg;

    localparam int unsigned F1_N_IN   = 4;
    localparam int unsigned F1_SETTLE = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Settle counter width: $clog2(settle+1) bits, and never less than 1.
    function automatic int unsigned cnt_width(input int unsigned settle);
        return (settle == 0) ? 1 : $clog2(settle + 1);
    endfunction

endpackage

// File: rtl/f1_settle_timer.sv
// Settle timer for the f1 sweep checker.
// Counts 0..SETTLE while clear is low and wraps back to 0 after the expiring cycle.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clear      : hold the count at 0
//   expire     : high while the count equals SETTLE
module f1_settle_timer
    import f1_sweep_checker_pkg::*;
#(
    parameter int unsigned SETTLE = F1_SETTLE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic expire
);

    localparam int unsigned CW = cnt_width(SETTLE);

    logic [CW-1:0] count;
    logic [CW-1:0] count_d;

    // Next count: restart on clear or after the expiring cycle.
    always_comb begin
        count_d = count;
        if (clear || expire) begin
            count_d = '0;
        end else begin
            count_d = CW'(count + CW'(1));
        end
    end

    // expire is registered from the next count, so it stays aligned with count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            expire <= 1'(SETTLE == 0);
        end else begin
            count  <= count_d;
            expire <= (count_d == CW'(SETTLE));
        end
    end

endmodule

// File: rtl/f1_sweep_checker.sv
// Stimulus/response checker wrapped around the combinational f1 function.
// It sweeps every input vector in ascending order and holds each vector for SETTLE+1
// cycles. It samples op into a captured truth table and compares that table with a
// golden table latched at start.
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset
//   start       : sweep request; accepted in IDLE or DONE only
//   expected    : golden truth table; bit k is the required op for vector k
//   op          : DUT output, combinational from vec
//   vec         : DUT input vector (vec[3..0] -> a,b,c,d)
//   busy        : sweep in progress
//   done        : sweep complete; held until the next accepted start
//   pass        : captured == expected, valid while done
//   captured    : sampled truth table
//   fail_valid  : at least one mismatch seen in this sweep
//   fail_idx    : index of the first mismatch, 0 if none
module f1_sweep_checker
    import f1_sweep_checker_pkg::*;
#(
    parameter int unsigned N_IN   = F1_N_IN,
    parameter int unsigned SETTLE = F1_SETTLE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [(2**N_IN)-1:0]   expected,
    input  logic                   op,
    output logic [N_IN-1:0]        vec,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [(2**N_IN)-1:0]   captured,
    output logic                   fail_valid,
    output logic [N_IN-1:0]        fail_idx
);

    localparam int unsigned NV = 2**N_IN;

    state_t          state, state_d;
    logic [N_IN-1:0] idx, idx_d;
    logic [NV-1:0]   expected_q, expected_d;
    logic [N_IN-1:0] vec_d;
    logic            busy_d, done_d, pass_d;
    logic [NV-1:0]   captured_d;
    logic            fail_valid_d;
    logic [N_IN-1:0] fail_idx_d;
    logic            expire;

    // Settle counter runs only while a vector is being held.
    f1_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state != S_HOLD),
        .expire (expire)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and next-value logic for all registered outputs.
    always_comb begin
        state_d      = state;
        idx_d        = idx;
        expected_d   = expected_q;
        vec_d        = vec;
        busy_d       = busy;
        done_d       = done;
        pass_d       = pass;
        captured_d   = captured;
        fail_valid_d = fail_valid;
        fail_idx_d   = fail_idx;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_HOLD;
                    expected_d   = expected;
                    idx_d        = '0;
                    vec_d        = '0;
                    captured_d   = '0;
                    fail_valid_d = 1'b0;
                    fail_idx_d   = '0;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    busy_d       = 1'b1;
                end
            end
            S_HOLD: begin
                if (expire) begin
                    captured_d[idx] = op;
                    // Only the first mismatch is recorded.
                    if ((op != expected_q[idx]) && !fail_valid) begin
                        fail_valid_d = 1'b1;
                        fail_idx_d   = idx;
                    end
                    if (idx == N_IN'(NV - 1)) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        vec_d   = '0;
                        pass_d  = (captured_d == expected_q);
                    end else begin
                        idx_d = N_IN'(idx + N_IN'(1));
                        vec_d = N_IN'(idx + N_IN'(1));
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            expected_q <= '0;
            vec        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            captured   <= '0;
            fail_valid <= 1'b0;
            fail_idx   <= '0;
        end else begin
            idx        <= idx_d;
            expected_q <= expected_d;
            vec        <= vec_d;
            busy       <= busy_d;
            done       <= done_d;
            pass       <= pass_d;
            captured   <= captured_d;
            fail_valid <= fail_valid_d;
            fail_idx   <= fail_idx_d;
        end
    end

endmodule

// File: tb/tb_f1_sweep_checker.sv
// Directed bench for f1_sweep_checker: default instance (SETTLE=2) plus a SETTLE=0 instance.
module tb_f1_sweep_checker;

    logic        clk;
    logic        rst_n;

    logic        start0;
    logic [15:0] expected0;
    logic        op0;
    logic [3:0]  vec0;
    logic        busy0, done0, pass0, fail_valid0;
    logic [15:0] captured0;
    logic [3:0]  fail_idx0;
    int          mode0;

    logic        start1;
    logic [15:0] expected1;
    logic        op1;
    logic [3:0]  vec1;
    logic        busy1, done1, pass1, fail_valid1;
    logic [15:0] captured1;
    logic [3:0]  fail_idx1;

    int total;
    int bad;

    // Bench-side f1 models: 0 = AND, 1 = XOR, 2 = OR of the vector bits.
    assign op0 = (mode0 == 0) ? (&vec0) : (mode0 == 1) ? (^vec0) : (|vec0);
    assign op1 = ^vec1;

    f1_sweep_checker u0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start0),
        .expected   (expected0),
        .op         (op0),
        .vec        (vec0),
        .busy       (busy0),
        .done       (done0),
        .pass       (pass0),
        .captured   (captured0),
        .fail_valid (fail_valid0),
        .fail_idx   (fail_idx0)
    );

    f1_sweep_checker #(.N_IN(4), .SETTLE(0)) u1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start1),
        .expected   (expected1),
        .op         (op1),
        .vec        (vec1),
        .busy       (busy1),
        .done       (done1),
        .pass       (pass1),
        .captured   (captured1),
        .fail_valid (fail_valid1),
        .fail_idx   (fail_idx1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          mode;
        logic [15:0] exp_tab;
        logic [15:0] want_cap;
        logic        want_pass;
        logic        want_fv;
        logic [3:0]  want_fi;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    // Starts a sweep on u0 and returns the edge count from the start edge to done.
    // pulse_at >= 1 re-pulses start and inverts expected0 at that cycle of the sweep.
    task automatic run0(input int pulse_at, output int lat);
        int n;
        @(posedge clk);
        #1 start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        check("start_busy", 32'(busy0), 32'd1);
        check("start_done", 32'(done0), 32'd0);
        n = 0;
        while (!done0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            start0 = (n == pulse_at);
            if (n == pulse_at) expected0 = ~expected0;
            if (n == 24) begin
                check("mid_pass_low", 32'(pass0), 32'd0);
                check("mid_busy", 32'(busy0), 32'd1);
            end
        end
        start0 = 1'b0;
        lat = n;
    endtask

    initial begin
        int lat;
        int n;
        total = 0;
        bad = 0;
        mode0 = 0;
        start0 = 1'b0;
        start1 = 1'b0;
        expected0 = 16'h8000;
        expected1 = 16'h6996;

        tbl[0] = '{0, 16'h8000, 16'h8000, 1'b1, 1'b0, 4'd0};
        tbl[1] = '{1, 16'h6997, 16'h6996, 1'b0, 1'b1, 4'd0};
        tbl[2] = '{1, 16'h6996, 16'h6996, 1'b1, 1'b0, 4'd0};
        tbl[3] = '{0, 16'h0000, 16'h8000, 1'b0, 1'b1, 4'd15};
        tbl[4] = '{2, 16'hFFFF, 16'hFFFE, 1'b0, 1'b1, 4'd0};
        tbl[5] = '{2, 16'h7FFE, 16'hFFFE, 1'b0, 1'b1, 4'd15};
        tbl[6] = '{1, 16'h6986, 16'h6996, 1'b0, 1'b1, 4'd4};

        // Reset state.
        rst_n = 1'b0;
        #1;
        check("rst_vec", 32'(vec0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_pass", 32'(pass0), 32'd0);
        check("rst_captured", 32'(captured0), 32'd0);
        check("rst_fail_valid", 32'(fail_valid0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven sweeps.
        for (int i = 0; i < 7; i++) begin
            mode0 = tbl[i].mode;
            expected0 = tbl[i].exp_tab;
            run0(-1, lat);
            check($sformatf("t%0d_latency", i), 32'(lat), 32'd48);
            check($sformatf("t%0d_captured", i), 32'(captured0), 32'(tbl[i].want_cap));
            check($sformatf("t%0d_pass", i), 32'(pass0), 32'(tbl[i].want_pass));
            check($sformatf("t%0d_fail_valid", i), 32'(fail_valid0), 32'(tbl[i].want_fv));
            check($sformatf("t%0d_fail_idx", i), 32'(fail_idx0), 32'(tbl[i].want_fi));
            check($sformatf("t%0d_idle_busy", i), 32'(busy0), 32'd0);
            check($sformatf("t%0d_vec_home", i), 32'(vec0), 32'd0);
        end

        // A start pulse mid-sweep is ignored, and so is a change to expected.
        mode0 = 0;
        expected0 = 16'h8000;
        run0(10, lat);
        check("restart_ignored_latency", 32'(lat), 32'd48);
        check("restart_ignored_captured", 32'(captured0), 32'h8000);
        check("restart_ignored_pass", 32'(pass0), 32'd1);
        expected0 = 16'h8000;

        // Reset mid-sweep clears every output before the next edge.
        mode0 = 1;
        expected0 = 16'h6996;
        @(posedge clk);
        #1 start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_vec", 32'(vec0), 32'd0);
        check("abort_busy", 32'(busy0), 32'd0);
        check("abort_done", 32'(done0), 32'd0);
        check("abort_pass", 32'(pass0), 32'd0);
        check("abort_captured", 32'(captured0), 32'd0);
        check("abort_fail_valid", 32'(fail_valid0), 32'd0);
        check("abort_fail_idx", 32'(fail_idx0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run0(-1, lat);
        check("post_abort_latency", 32'(lat), 32'd48);
        check("post_abort_pass", 32'(pass1 | pass0), 32'd1);
        check("post_abort_captured", 32'(captured0), 32'h6996);

        // SETTLE=0 instance: 16-cycle sweep, then a restart in the done cycle.
        @(posedge clk);
        #1 start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        n = 0;
        while (!done1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("s0_latency", 32'(n), 32'd16);
        check("s0_pass", 32'(pass1), 32'd1);
        check("s0_captured", 32'(captured1), 32'h6996);
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        check("s0_restart_done", 32'(done1), 32'd0);
        check("s0_restart_busy", 32'(busy1), 32'd1);
        check("s0_restart_pass", 32'(pass1), 32'd0);
        n = 0;
        while (!done1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("s0_restart_latency", 32'(n), 32'd16);
        check("s0_restart_pass_final", 32'(pass1), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
